// File: rtl/ddr_frame_rd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ddr_frame_rd_ctrl
// Desc     : Walks one DDR frame buffer with fixed-length read bursts and
//            pushes the returned beats into the video line FIFO. A burst is
//            requested only when the FIFO water level leaves room for all of
//            it. Single clock domain (DDR user clock = FIFO write clock).
// Options  : DDR_FRAME_RD_ERR_CHK_EN - builds the sticky protocol/overflow
//            error checker driving err; when undefined err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_frame_rd_ctrl #(
   parameter int                    ADDR_WIDTH       = 28,
   parameter int                    DATA_WIDTH       = 128,
   parameter int                    BURST_LEN        = 16,
   parameter int                    FIFO_DEPTH_WIDTH = 11,
   parameter int                    FRAME_BURSTS     = 7200,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR        = '0
) (
   input  logic                      wr_clk,
   input  logic                      wr_rst,
   input  logic                      frame_start,
   input  logic [FIFO_DEPTH_WIDTH:0] fifo_water_level,
   input  logic                      fifo_full,
   output logic                      fifo_wr_en,
   output logic [DATA_WIDTH-1:0]     fifo_wr_data,
   output logic [ADDR_WIDTH-1:0]     rd_addr,
   output logic [7:0]                rd_len,
   output logic                      rd_addr_valid,
   input  logic                      rd_addr_ready,
   input  logic [DATA_WIDTH-1:0]     rd_data,
   input  logic                      rd_data_valid,
   input  logic                      rd_data_last,
   output logic                      busy,
   output logic                      frame_done,
   output logic                      err
);

   // Burst counter must be able to hold FRAME_BURSTS itself.
   localparam int                        c_IDX_W        = $clog2(FRAME_BURSTS + 1);
   localparam logic [ADDR_WIDTH-1:0]     c_burst_bytes  = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);
   // Highest water level that still leaves room for one whole burst.
   localparam logic [FIFO_DEPTH_WIDTH:0] c_space_thresh =
      (FIFO_DEPTH_WIDTH + 1)'((1 << FIFO_DEPTH_WIDTH) - BURST_LEN);
   localparam logic [c_IDX_W-1:0]        c_last_idx     = c_IDX_W'(FRAME_BURSTS);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WAIT_SPACE = 3'd1,
      S_REQ        = 3'd2,
      S_DATA       = 3'd3,
      S_SETTLE     = 3'd4
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic [c_IDX_W-1:0]    r_burst_idx;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_settle_cnt;
   logic                  r_restart_pend;
   logic                  r_fifo_wr_en;
   logic [DATA_WIDTH-1:0] r_fifo_wr_data;
   logic                  r_frame_done;

   logic                  w_clear_ctrs;
   logic                  w_adv_ctrs;
   logic                  w_set_pend;
   logic                  w_frame_done;
   logic                  w_has_space;

   assign w_has_space = (fifo_water_level <= c_space_thresh);

   // State register.
   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic and counter/flag control strobes.
   always_comb begin
      w_next_state = r_state;
      w_clear_ctrs = 1'b0;
      w_adv_ctrs   = 1'b0;
      w_set_pend   = 1'b0;
      w_frame_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (frame_start) begin
               w_clear_ctrs = 1'b1;
               w_next_state = S_WAIT_SPACE;
            end
         end
         S_WAIT_SPACE: begin
            // Nothing is in flight, so a restart takes effect immediately.
            if (frame_start) begin
               w_clear_ctrs = 1'b1;
            end else if (w_has_space) begin
               w_next_state = S_REQ;
            end
         end
         S_REQ: begin
            w_set_pend = frame_start;
            if (rd_addr_ready) begin
               w_next_state = S_DATA;
            end
         end
         S_DATA: begin
            w_set_pend = frame_start;
            if (rd_data_valid && rd_data_last) begin
               w_adv_ctrs   = 1'b1;
               w_next_state = S_SETTLE;
            end
         end
         S_SETTLE: begin
            w_set_pend = frame_start;
            if (r_settle_cnt) begin
               // A restart arriving on the final exit beats frame_done.
               if (r_restart_pend || frame_start) begin
                  w_clear_ctrs = 1'b1;
                  w_next_state = S_WAIT_SPACE;
               end else if (r_burst_idx == c_last_idx) begin
                  w_frame_done = 1'b1;
                  w_next_state = S_IDLE;
               end else begin
                  w_next_state = S_WAIT_SPACE;
               end
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Burst index and address walk through the frame buffer.
   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         r_burst_idx <= '0;
         r_addr      <= BASE_ADDR;
      end else if (w_clear_ctrs) begin
         r_burst_idx <= '0;
         r_addr      <= BASE_ADDR;
      end else if (w_adv_ctrs) begin
         r_burst_idx <= r_burst_idx + c_IDX_W'(1);
         r_addr      <= r_addr + c_burst_bytes;
      end
   end

   // Restart request latched while a burst is in flight.
   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         r_restart_pend <= 1'b0;
      end else if (w_clear_ctrs) begin
         r_restart_pend <= 1'b0;
      end else if (w_set_pend) begin
         r_restart_pend <= 1'b1;
      end
   end

   // Two-cycle settle timer so the water level catches up with the writes.
   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         r_settle_cnt <= 1'b0;
      end else if (r_state == S_SETTLE) begin
         r_settle_cnt <= ~r_settle_cnt;
      end else begin
         r_settle_cnt <= 1'b0;
      end
   end

   // Register returned beats into the FIFO write port.
   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         r_fifo_wr_en   <= 1'b0;
         r_fifo_wr_data <= '0;
      end else begin
         r_fifo_wr_en <= (r_state == S_DATA) && rd_data_valid;
         if ((r_state == S_DATA) && rd_data_valid) begin
            r_fifo_wr_data <= rd_data;
         end
      end
   end

   // One-cycle end-of-frame pulse.
   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_frame_done;
      end
   end

   assign fifo_wr_en    = r_fifo_wr_en;
   assign fifo_wr_data  = r_fifo_wr_data;
   assign rd_addr       = r_addr;
   assign rd_len        = 8'(BURST_LEN - 1);
   assign rd_addr_valid = (r_state == S_REQ);
   assign busy          = (r_state != S_IDLE);
   assign frame_done    = r_frame_done;

`ifdef DDR_FRAME_RD_ERR_CHK_EN
   logic [8:0] r_beat_cnt;
   logic       r_err;
   logic       w_err_set;

   // Beats seen in the current burst; only used to judge rd_data_last.
   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         r_beat_cnt <= '0;
      end else if (r_state != S_DATA) begin
         r_beat_cnt <= '0;
      end else if (rd_data_valid) begin
         r_beat_cnt <= r_beat_cnt + 9'd1;
      end
   end

   assign w_err_set = (fifo_full && r_fifo_wr_en)
                    || (rd_data_valid && (r_state != S_DATA))
                    || ((r_state == S_DATA) && rd_data_valid && rd_data_last
                        && (r_beat_cnt != 9'(BURST_LEN - 1)));

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         r_err <= 1'b0;
      end else if (w_err_set) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   logic w_unused_fifo_full;
   assign w_unused_fifo_full = fifo_full;
   assign err                = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr_frame_rd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ddr_frame_rd_ctrl
// Desc     : Self-checking bench for ddr_frame_rd_ctrl with a 4-burst frame.
//            Random beat gaps, ready stalls, water levels and data are checked
//            against an address/frame model computed from burst arithmetic.
// Options  : DDR_FRAME_RD_ERR_CHK_EN changes the expected err behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_frame_rd_ctrl;

   localparam int              AW          = 28;
   localparam int              DW          = 128;
   localparam int              BL          = 16;
   localparam int              FDW         = 11;
   localparam int              FB          = 4;
   localparam int              LW          = FDW + 1;
   localparam logic [AW-1:0]   BASE        = '0;
   localparam int              BURST_BYTES = BL * DW / 8;
   localparam int              THRESH      = (1 << FDW) - BL;
   localparam int              WAIT_LIMIT  = 200;
`ifdef DDR_FRAME_RD_ERR_CHK_EN
   localparam logic            EXP_ERR_ON  = 1'b1;
`else
   localparam logic            EXP_ERR_ON  = 1'b0;
`endif

   logic          wr_clk = 1'b0;
   logic          wr_rst;
   logic          frame_start;
   logic [LW-1:0] fifo_water_level;
   logic          fifo_full;
   logic          fifo_wr_en;
   logic [DW-1:0] fifo_wr_data;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_len;
   logic          rd_addr_valid;
   logic          rd_addr_ready;
   logic [DW-1:0] rd_data;
   logic          rd_data_valid;
   logic          rd_data_last;
   logic          busy;
   logic          frame_done;
   logic          err;

   int n_checks = 0;
   int n_pass   = 0;
   int model_idx;

   always #5 wr_clk = ~wr_clk;

   ddr_frame_rd_ctrl #(
      .ADDR_WIDTH       (AW),
      .DATA_WIDTH       (DW),
      .BURST_LEN        (BL),
      .FIFO_DEPTH_WIDTH (FDW),
      .FRAME_BURSTS     (FB),
      .BASE_ADDR        (BASE)
   ) dut (
      .wr_clk           (wr_clk),
      .wr_rst           (wr_rst),
      .frame_start      (frame_start),
      .fifo_water_level (fifo_water_level),
      .fifo_full        (fifo_full),
      .fifo_wr_en       (fifo_wr_en),
      .fifo_wr_data     (fifo_wr_data),
      .rd_addr          (rd_addr),
      .rd_len           (rd_len),
      .rd_addr_valid    (rd_addr_valid),
      .rd_addr_ready    (rd_addr_ready),
      .rd_data          (rd_data),
      .rd_data_valid    (rd_data_valid),
      .rd_data_last     (rd_data_last),
      .busy             (busy),
      .frame_done       (frame_done),
      .err              (err)
   );

   // Reference model: burst k of a frame starts at BASE + k * burst bytes.
   function automatic logic [AW-1:0] model_addr(input int idx);
      return BASE + AW'(idx * BURST_BYTES);
   endfunction

   task automatic tick();
      @(posedge wr_clk);
      #1;
   endtask

   task automatic do_reset();
      wr_rst           = 1'b1;
      frame_start      = 1'b0;
      fifo_water_level = '0;
      fifo_full        = 1'b0;
      rd_addr_ready    = 1'b0;
      rd_data          = '0;
      rd_data_valid    = 1'b0;
      rd_data_last     = 1'b0;
      tick();
      tick();
      wr_rst = 1'b0;
      tick();
      model_idx = 0;
   endtask

   task automatic pulse_start();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   // One burst: wait for the request, optionally stall ready, stream beats.
   task automatic run_burst(input int exp_wait, input int stall, input int nbeats,
                            input int restart_beat, input logic full_during);
      int            waited;
      int            b;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] beat;
      logic          drove;
      exp_addr = model_addr(model_idx);
      waited   = 0;
      beat     = '0;
      while (rd_addr_valid !== 1'b1 && waited < WAIT_LIMIT) begin
         fifo_water_level = LW'($urandom_range(0, THRESH));
         tick();
         waited++;
      end
      n_checks++;
      if (rd_addr_valid !== 1'b1) begin
         $display("FAIL req_timeout: rd_addr_valid=%b after %0d cycles, required 1", rd_addr_valid, waited);
         return;
      end else n_pass++;
      if (exp_wait >= 0) begin
         n_checks++;
         if (waited != exp_wait)
            $display("FAIL req_latency: request after %0d cycles, required %0d", waited, exp_wait);
         else n_pass++;
      end
      n_checks++;
      if (rd_addr !== exp_addr || rd_len !== 8'(BL - 1))
         $display("FAIL req_addr: addr=%h len=%0d, required addr=%h len=%0d", rd_addr, rd_len, exp_addr, BL - 1);
      else n_pass++;
      for (int i = 0; i < stall; i++) begin
         tick();
         n_checks++;
         if (rd_addr_valid !== 1'b1 || rd_addr !== exp_addr)
            $display("FAIL req_stable: valid=%b addr=%h, required valid=1 addr=%h", rd_addr_valid, rd_addr, exp_addr);
         else n_pass++;
      end
      rd_addr_ready = 1'b1;
      tick();
      rd_addr_ready = 1'b0;
      n_checks++;
      if (rd_addr_valid !== 1'b0)
         $display("FAIL req_accept: rd_addr_valid=%b after handshake, required 0", rd_addr_valid);
      else n_pass++;
      b         = 0;
      fifo_full = full_during;
      while (b < nbeats) begin
         drove = ($urandom_range(0, 3) != 0);
         if (drove) begin
            beat          = {$urandom(), $urandom(), $urandom(), $urandom()};
            rd_data       = beat;
            rd_data_valid = 1'b1;
            rd_data_last  = (b == nbeats - 1);
            frame_start   = (b == restart_beat);
            b++;
         end else begin
            rd_data       = {$urandom(), $urandom(), $urandom(), $urandom()};
            rd_data_valid = 1'b0;
            rd_data_last  = 1'b0;
         end
         tick();
         frame_start = 1'b0;
         n_checks++;
         if (fifo_wr_en !== drove || (drove && fifo_wr_data !== beat))
            $display("FAIL fifo_write: en=%b data=%h, required en=%b data=%h", fifo_wr_en, fifo_wr_data, drove, beat);
         else n_pass++;
      end
      rd_data_valid = 1'b0;
      rd_data_last  = 1'b0;
      fifo_full     = 1'b0;
      if (restart_beat >= 0) model_idx = 0;
      else model_idx++;
   endtask

   // Called one cycle after the final beat of a frame.
   task automatic check_frame_end();
      tick();
      n_checks++;
      if (frame_done !== 1'b0 || busy !== 1'b1)
         $display("FAIL frame_end_early: frame_done=%b busy=%b, required 0/1", frame_done, busy);
      else n_pass++;
      tick();
      n_checks++;
      if (frame_done !== 1'b1 || busy !== 1'b0)
         $display("FAIL frame_done: frame_done=%b busy=%b, required 1/0", frame_done, busy);
      else n_pass++;
      tick();
      n_checks++;
      if (frame_done !== 1'b0 || rd_addr_valid !== 1'b0)
         $display("FAIL frame_done_pulse: frame_done=%b valid=%b, required 0/0", frame_done, rd_addr_valid);
      else n_pass++;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (rd_addr_valid !== 1'b0 || rd_addr !== BASE || rd_len !== 8'(BL - 1))
         $display("FAIL reset_req: valid=%b addr=%h len=%0d, required 0/%h/%0d", rd_addr_valid, rd_addr, rd_len, BASE, BL - 1);
      else n_pass++;
      n_checks++;
      if (fifo_wr_en !== 1'b0 || fifo_wr_data !== '0)
         $display("FAIL reset_fifo: en=%b data=%h, required 0/0", fifo_wr_en, fifo_wr_data);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0 || frame_done !== 1'b0 || err !== 1'b0)
         $display("FAIL reset_status: busy=%b done=%b err=%b, required 0/0/0", busy, frame_done, err);
      else n_pass++;
   endtask

   task automatic test_full_frame();
      do_reset();
      pulse_start();
      n_checks++;
      if (rd_addr_valid !== 1'b0 || busy !== 1'b1)
         $display("FAIL start_cycle1: valid=%b busy=%b, required 0/1", rd_addr_valid, busy);
      else n_pass++;
      run_burst(1, 0, BL, -1, 1'b0);
      for (int k = 1; k < FB; k++) run_burst(3, $urandom_range(0, 3), BL, -1, 1'b0);
      check_frame_end();
   endtask

   task automatic test_water_level();
      do_reset();
      fifo_water_level = LW'(THRESH + 1);
      pulse_start();
      for (int i = 0; i < 10; i++) begin
         tick();
         n_checks++;
         if (rd_addr_valid !== 1'b0)
            $display("FAIL level_block: rd_addr_valid=%b at level %0d, required 0", rd_addr_valid, THRESH + 1);
         else n_pass++;
      end
      fifo_water_level = LW'(THRESH);
      tick();
      n_checks++;
      if (rd_addr_valid !== 1'b1)
         $display("FAIL level_release: rd_addr_valid=%b at level %0d, required 1", rd_addr_valid, THRESH);
      else n_pass++;
   endtask

   task automatic test_ready_stall();
      do_reset();
      pulse_start();
      run_burst(1, 10, BL, -1, 1'b0);
   endtask

   task automatic test_restart_during_data();
      do_reset();
      pulse_start();
      run_burst(1, 0, BL, -1, 1'b0);
      run_burst(3, 0, BL, -1, 1'b0);
      run_burst(3, $urandom_range(0, 2), BL, $urandom_range(1, BL - 2), 1'b0);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (frame_done !== 1'b0 || busy !== 1'b1)
            $display("FAIL restart_no_done: frame_done=%b busy=%b, required 0/1", frame_done, busy);
         else n_pass++;
         tick();
      end
      run_burst(0, 0, BL, -1, 1'b0);
      for (int k = 1; k < FB; k++) run_burst(3, $urandom_range(0, 3), BL, -1, 1'b0);
      check_frame_end();
   endtask

   task automatic test_restart_at_frame_end();
      do_reset();
      pulse_start();
      run_burst(1, 0, BL, -1, 1'b0);
      for (int k = 1; k < FB; k++) run_burst(3, 0, BL, -1, 1'b0);
      tick();
      pulse_start();
      n_checks++;
      if (frame_done !== 1'b0 || busy !== 1'b1)
         $display("FAIL restart_wins: frame_done=%b busy=%b, required 0/1", frame_done, busy);
      else n_pass++;
      model_idx = 0;
      run_burst(1, 0, BL, -1, 1'b0);
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      pulse_start();
      tick();
      rd_addr_ready = 1'b1;
      tick();
      rd_addr_ready = 1'b0;
      rd_data_valid = 1'b1;
      rd_data       = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      tick();
      wr_rst = 1'b1;
      #2;
      n_checks++;
      if (fifo_wr_en !== 1'b0 || busy !== 1'b0 || rd_addr_valid !== 1'b0)
         $display("FAIL async_reset: en=%b busy=%b valid=%b, required 0/0/0", fifo_wr_en, busy, rd_addr_valid);
      else n_pass++;
      tick();
      wr_rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rd_data      = {$urandom(), $urandom(), $urandom(), $urandom()};
         rd_data_last = (i == 3);
         tick();
         n_checks++;
         if (fifo_wr_en !== 1'b0 || busy !== 1'b0)
            $display("FAIL stale_beats: en=%b busy=%b, required 0/0", fifo_wr_en, busy);
         else n_pass++;
      end
      rd_data_valid = 1'b0;
      rd_data_last  = 1'b0;
      n_checks++;
      if (err !== EXP_ERR_ON)
         $display("FAIL err_stale: err=%b, required %b", err, EXP_ERR_ON);
      else n_pass++;
   endtask

   task automatic test_err_early_last();
      do_reset();
      n_checks++;
      if (err !== 1'b0)
         $display("FAIL err_clear: err=%b after reset, required 0", err);
      else n_pass++;
      pulse_start();
      run_burst(1, 0, BL / 2, -1, 1'b0);
      n_checks++;
      if (err !== EXP_ERR_ON)
         $display("FAIL err_early_last: err=%b, required %b", err, EXP_ERR_ON);
      else n_pass++;
      run_burst(3, 0, BL, -1, 1'b0);
   endtask

   task automatic test_err_full();
      do_reset();
      pulse_start();
      run_burst(1, 0, BL, -1, 1'b1);
      n_checks++;
      if (err !== EXP_ERR_ON)
         $display("FAIL err_fifo_full: err=%b, required %b", err, EXP_ERR_ON);
      else n_pass++;
   endtask

   initial begin
      wr_rst = 1'b1;
      test_reset();
      test_full_frame();
      test_water_level();
      test_ready_stall();
      test_restart_during_data();
      test_restart_at_frame_end();
      test_reset_mid_burst();
      test_err_early_last();
      test_err_full();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/ddr_frame_rd_ctrl.md
# ddr_frame_rd_ctrl

Write-side feeder for the 128-to-16-bit video line FIFO in the DDR-to-HDMI loop path. The block issues fixed-length DDR read bursts that walk one frame buffer, then pushes the returned 128-bit beats into the FIFO. It issues a burst only when the FIFO write-side water level guarantees room for the whole burst, so the FIFO never overflows. It runs entirely in the DDR user clock domain, which is the FIFO write domain.

## Interface
Parameters:
- ADDR_WIDTH, 28, DDR byte-address width.
- DATA_WIDTH, 128, beat width; equals the FIFO write width.
- BURST_LEN, 16, beats per burst, range 2..256.
- FIFO_DEPTH_WIDTH, 11, FIFO write depth is 2^FIFO_DEPTH_WIDTH words (2048).
- FRAME_BURSTS, 7200, bursts per frame (1280x720x16 bit / 128 / 16).
- BASE_ADDR, 0, frame buffer start byte address.

Ports:
- wr_clk  in  1  DDR user clock, which is also the FIFO write clock.
- wr_rst  in  1  reset; asynchronous assert, active-high.
- frame_start  in  1  one-cycle pulse that starts or restarts a frame; already synchronous to wr_clk.
- fifo_water_level  in  FIFO_DEPTH_WIDTH+1  FIFO wr_water_level.
- fifo_full  in  1  FIFO wr_full.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_wr_data  out  DATA_WIDTH  FIFO write data.
- rd_addr  out  ADDR_WIDTH  burst start byte address.
- rd_len  out  8  burst length, BURST_LEN-1.
- rd_addr_valid  out  1  address request valid.
- rd_addr_ready  in  1  address accepted.
- rd_data  in  DATA_WIDTH  returned read beat.
- rd_data_valid  in  1  beat valid.
- rd_data_last  in  1  final beat of the burst.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse after the last beat of a frame is written.
- err  out  1  sticky error flag; see Configuration.

## Operation
- States: IDLE, WAIT_SPACE, REQ, DATA, SETTLE.
- IDLE:
  - On frame_start: burst_idx=0, addr=BASE_ADDR, go to WAIT_SPACE.
  - busy=0.
- WAIT_SPACE:
  - Advance to REQ when fifo_water_level <= 2^FIFO_DEPTH_WIDTH - BURST_LEN.
- REQ:
  - rd_addr_valid=1 with rd_addr=addr.
  - On rd_addr_ready, go to DATA.
  - rd_addr and rd_addr_valid stay stable until ready; a request is never withdrawn.
- DATA:
  - Each rd_data_valid beat is registered into fifo_wr_en/fifo_wr_data.
  - Count beats. On rd_data_valid & rd_data_last, burst_idx+=1, addr+=BURST_LEN*DATA_WIDTH/8 (wraps modulo 2^ADDR_WIDTH), go to SETTLE.
  - The beat counter is diagnostic only; rd_data_last is authoritative.
- SETTLE:
  - Hold 2 cycles so the FIFO water level reflects the last writes.
  - Then, if burst_idx==FRAME_BURSTS: pulse frame_done, go to IDLE. Otherwise go to WAIT_SPACE.
- frame_start outside IDLE:
  - Sets restart_pend.
  - In WAIT_SPACE, restart_pend is consumed immediately: burst_idx=0, addr=BASE_ADDR, stay in WAIT_SPACE.
  - In REQ or DATA, the burst in flight completes and its beats are still written. restart_pend is consumed on exit from SETTLE, which goes to WAIT_SPACE with reset counters and no frame_done pulse.
- frame_start coinciding with the final SETTLE exit: restart wins and frame_done is suppressed.
- busy=1 in every state except IDLE.

## Timing
- Reset values:
  - state=IDLE.
  - rd_addr_valid=0, rd_addr=BASE_ADDR, rd_len=BURST_LEN-1 (constant).
  - fifo_wr_en=0, fifo_wr_data=0.
  - busy=0, frame_done=0, err=0, restart_pend=0.
- frame_start to first rd_addr_valid: 2 cycles when the FIFO has space.
- rd_data_valid to fifo_wr_en: 1 cycle, fully registered, no combinational path.
- Minimum gap from the last beat to the next rd_addr_valid: 4 cycles (write register, 2 SETTLE cycles, WAIT_SPACE).
- wr_rst asserted mid-burst: all state is cleared immediately. Any beats still returning after reset release are ignored because the state is IDLE.

## Configuration
- Macro DDR_FRAME_RD_ERR_CHK_EN.
- Defined:
  - err is set by fifo_full & fifo_wr_en.
  - err is set by rd_data_valid outside DATA.
  - err is set by rd_data_last arriving on a beat other than beat BURST_LEN.
  - err clears only on wr_rst.
- Undefined: err is tied 0 and no check logic is built.

## Test plan
- Reset then frame_start with water level 0: rd_addr_valid at cycle 2, rd_addr=0, rd_len=15. Sixteen beats D0..D15 appear on fifo_wr_data one cycle after each is valid.
- Water level held at 2033: no request. Drop it to 2032: rd_addr_valid asserts on the next cycle.
- Full frame with FRAME_BURSTS=4 in the bench: addresses 0x000, 0x100, 0x200, 0x300, then frame_done for one cycle and busy=0.
- rd_addr_ready held low for 10 cycles: rd_addr_valid and rd_addr stay stable throughout; the handshake completes on the first ready.
- frame_start during DATA of burst 2: the remaining beats are still written, there is no frame_done, and the next request is at BASE_ADDR.
- With DDR_FRAME_RD_ERR_CHK_EN: rd_data_last on beat 8 sets err=1. With fifo_full forced high during a write, err=1. Without the macro, err stays 0 in both cases.
